decode_stage: RTL and testbench

- Registered, handshaked RV32I instruction-decode pipeline stage. Sits between the fetch unit and the execute stage.
- Wraps the combinational decode rules (ALU op, operand selects, memory and writeback controls, branch/jump flags) in valid/ready flow control with a 2-entry skid buffer and a flush input.
- Adds optional Zicsr/MRET decode and a saturating illegal-instruction counter.

---
 rtl/decode_stage_pkg.sv | 94 +++++++++
 rtl/decode_comb.sv | 112 +++++++++++
 rtl/decode_stage.sv | 149 ++++++++++++++
 tb/tb_decode_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode encodings and the decoded-bundle type used by the
// decode stage and its combinational decoder.
package decode_stage_pkg;

    localparam int ALU_OP_WIDTH = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] OP_A_RS1  = 2'd0;
    localparam logic [1:0] OP_A_PC   = 2'd1;
    localparam logic [1:0] OP_A_ZERO = 2'd2;

    localparam logic [2:0] OP_B_RS2   = 3'd0;
    localparam logic [2:0] OP_B_IMM_I = 3'd1;
    localparam logic [2:0] OP_B_IMM_S = 3'd2;
    localparam logic [2:0] OP_B_IMM_U = 3'd4;
    localparam logic [2:0] OP_B_FOUR  = 3'd6;

    // Arithmetic ops are {1'b0, funct7[5], funct3}; compares are {2'b10, funct3}.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 5'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 5'd16;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 5'd17;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LT   = 5'd20;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GE   = 5'd21;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 5'd22;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 5'd23;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic WB_EX_RESULT = 1'b0;
    localparam logic WB_LSU_DATA  = 1'b1;

    localparam logic [2:0] CSR_OP_RW  = 3'b001;
    localparam logic [2:0] CSR_OP_RS  = 3'b010;
    localparam logic [2:0] CSR_OP_RC  = 3'b011;
    localparam logic [2:0] CSR_OP_RWI = 3'b101;
    localparam logic [2:0] CSR_OP_RSI = 3'b110;
    localparam logic [2:0] CSR_OP_RCI = 3'b111;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    typedef struct packed {
        logic [1:0]              op_a_sel;
        logic [2:0]              op_b_sel;
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic                    mem_req;
        logic                    mem_we;
        logic [2:0]              mem_size;
        logic                    gpr_we;
        logic                    wb_src_sel;
        logic                    branch;
        logic                    jal;
        logic                    jalr;
        logic                    csr_we;
        logic [2:0]              csr_op;
        logic                    mret;
        logic                    illegal;
    } decode_bundle_t;

    localparam decode_bundle_t BUNDLE_RST = '{
        op_a_sel:   OP_A_RS1,
        op_b_sel:   OP_B_RS2,
        alu_op:     ALU_ADD,
        mem_size:   LDST_W,
        wb_src_sel: WB_EX_RESULT,
        default:    '0
    };

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I (+ optional Zicsr/MRET) decoder. Illegal encodings
// produce the idle bundle with only the illegal flag raised.
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter bit CSR_EN = 1'b1
) (
    input  logic [31:0]    instr_i,
    output decode_bundle_t bundle_o
);

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic           legal;
    decode_bundle_t b;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        b     = BUNDLE_RST;
        legal = 1'b1;
        case (opcode)
            OPC_LUI: begin
                b.op_a_sel = OP_A_ZERO;
                b.op_b_sel = OP_B_IMM_U;
                b.gpr_we   = 1'b1;
            end
            OPC_AUIPC: begin
                b.op_a_sel = OP_A_PC;
                b.op_b_sel = OP_B_IMM_U;
                b.gpr_we   = 1'b1;
            end
            OPC_JAL: begin
                b.op_a_sel = OP_A_PC;
                b.op_b_sel = OP_B_FOUR;
                b.gpr_we   = 1'b1;
                b.jal      = 1'b1;
            end
            OPC_JALR: begin
                legal      = (funct3 == 3'd0);
                b.op_a_sel = OP_A_PC;
                b.op_b_sel = OP_B_FOUR;
                b.gpr_we   = 1'b1;
                b.jalr     = 1'b1;
            end
            OPC_BRANCH: begin
                legal    = (funct3 != 3'd2) && (funct3 != 3'd3);
                b.alu_op = {2'b10, funct3};
                b.branch = 1'b1;
            end
            OPC_LOAD: begin
                legal        = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                b.op_b_sel   = OP_B_IMM_I;
                b.mem_req    = 1'b1;
                b.mem_size   = funct3;
                b.gpr_we     = 1'b1;
                b.wb_src_sel = WB_LSU_DATA;
            end
            OPC_STORE: begin
                legal      = (funct3 <= 3'd2);
                b.op_b_sel = OP_B_IMM_S;
                b.mem_req  = 1'b1;
                b.mem_we   = 1'b1;
                b.mem_size = funct3;
            end
            OPC_OP_IMM: begin
                // Only shift-immediates constrain funct7; SRAI reuses the SUB/SRA bit.
                if (funct3 == 3'd1)      legal = (funct7 == 7'h00);
                else if (funct3 == 3'd5) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                b.op_b_sel = OP_B_IMM_I;
                b.alu_op   = {1'b0, (funct3 == 3'd5) & funct7[5], funct3};
                b.gpr_we   = 1'b1;
            end
            OPC_OP: begin
                legal    = (funct7 == 7'h00) ||
                           ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
                b.alu_op = {1'b0, funct7[5], funct3};
                b.gpr_we = 1'b1;
            end
            OPC_FENCE: begin
                legal = (funct3 == 3'd0);
            end
            OPC_SYSTEM: begin
                if (!CSR_EN) begin
                    legal = 1'b0;
                end else if (funct3 == 3'd0) begin
                    legal  = (instr_i == INSTR_ECALL) || (instr_i == INSTR_EBREAK) ||
                             (instr_i == INSTR_MRET);
                    b.mret = (instr_i == INSTR_MRET);
                end else if (funct3 == 3'd4) begin
                    legal = 1'b0;
                end else begin
                    b.gpr_we = 1'b1;
                    b.csr_we = 1'b1;
                    b.csr_op = funct3;
                end
            end
            default: legal = 1'b0;
        endcase
        if (instr_i[1:0] != 2'b11) legal = 1'b0;
        if (!legal) begin
            b         = BUNDLE_RST;
            b.illegal = 1'b1;
        end
    end

    assign bundle_o = b;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on the input path, holds up to two
// decoded bundles (output register + skid), with flush and illegal counter.
//
// state    | meaning
// EMPTY    | output register holds nothing
// HOLD     | output register valid, skid empty
// FULL     | output register and skid both valid
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit CSR_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             instr_i,
    input  logic [XLEN-1:0]         pc_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [31:0]             instr_o,
    output logic [XLEN-1:0]         pc_o,
    output logic [1:0]              ex_op_a_sel_o,
    output logic [2:0]              ex_op_b_sel_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [2:0]              mem_size_o,
    output logic                    gpr_we_a_o,
    output logic                    wb_src_sel_o,
    output logic                    branch_o,
    output logic                    jal_o,
    output logic                    jalr_o,
    output logic                    csr_we_o,
    output logic [2:0]              csr_op_o,
    output logic                    mret_o,
    output logic                    illegal_instr_o,
    output logic [CNT_W-1:0]        illegal_cnt_o
);

    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_FULL} state_e;

    state_e         state_q;
    decode_bundle_t dec_d;
    decode_bundle_t out_q, skid_q;
    logic [31:0]    out_instr_q, skid_instr_q;
    logic [XLEN-1:0] out_pc_q, skid_pc_q;
    logic           in_ready_q, out_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic           accept, drain;

    assign accept = in_valid_i & in_ready_q;
    assign drain  = out_valid_q & out_ready_i;

    decode_comb #(.CSR_EN(CSR_EN)) u_decode_comb (
        .instr_i  (instr_i),
        .bundle_o (dec_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_q        <= BUNDLE_RST;
            skid_q       <= BUNDLE_RST;
            out_instr_q  <= '0;
            skid_instr_q <= '0;
            out_pc_q     <= '0;
            skid_pc_q    <= '0;
            cnt_q        <= '0;
        end else begin
            // A bundle taken by execute counts even if a flush lands in the same cycle.
            if (drain && out_q.illegal && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
            if (flush_i) begin
                state_q     <= ST_EMPTY;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            out_q       <= dec_d;
                            out_instr_q <= instr_i;
                            out_pc_q    <= pc_i;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (accept && drain) begin
                            out_q       <= dec_d;
                            out_instr_q <= instr_i;
                            out_pc_q    <= pc_i;
                        end else if (accept) begin
                            skid_q       <= dec_d;
                            skid_instr_q <= instr_i;
                            skid_pc_q    <= pc_i;
                            in_ready_q   <= 1'b0;
                            state_q      <= ST_FULL;
                        end else if (drain) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (drain) begin
                            out_q       <= skid_q;
                            out_instr_q <= skid_instr_q;
                            out_pc_q    <= skid_pc_q;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_HOLD;
                        end
                    end
                    default: begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    assign in_ready_o      = in_ready_q;
    assign out_valid_o     = out_valid_q;
    assign instr_o         = out_instr_q;
    assign pc_o            = out_pc_q;
    assign ex_op_a_sel_o   = out_q.op_a_sel;
    assign ex_op_b_sel_o   = out_q.op_b_sel;
    assign alu_op_o        = out_q.alu_op;
    assign mem_req_o       = out_q.mem_req;
    assign mem_we_o        = out_q.mem_we;
    assign mem_size_o      = out_q.mem_size;
    assign gpr_we_a_o      = out_q.gpr_we;
    assign wb_src_sel_o    = out_q.wb_src_sel;
    assign branch_o        = out_q.branch;
    assign jal_o           = out_q.jal;
    assign jalr_o          = out_q.jalr;
    assign csr_we_o        = out_q.csr_we;
    assign csr_op_o        = out_q.csr_op;
    assign mret_o          = out_q.mret;
    assign illegal_instr_o = out_q.illegal;
    assign illegal_cnt_o   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (CSR on / 16-bit counter, CSR off /
// 2-bit counter) share stimulus and are checked against a queue model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, pc;

    logic        in_ready [2];
    logic        out_valid [2];
    logic [31:0] instr_o [2];
    logic [31:0] pc_o [2];
    logic [1:0]  op_a [2];
    logic [2:0]  op_b [2];
    logic [4:0]  alu [2];
    logic        mreq [2], mwe [2], gwe [2], wb [2], br [2], jal [2], jalr [2], cwe [2], mret [2], ill [2];
    logic [2:0]  msz [2], cop [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .CSR_EN(1'b1), .CNT_W(16)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
        .instr_o(instr_o[0]), .pc_o(pc_o[0]), .ex_op_a_sel_o(op_a[0]), .ex_op_b_sel_o(op_b[0]),
        .alu_op_o(alu[0]), .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_size_o(msz[0]),
        .gpr_we_a_o(gwe[0]), .wb_src_sel_o(wb[0]), .branch_o(br[0]), .jal_o(jal[0]), .jalr_o(jalr[0]),
        .csr_we_o(cwe[0]), .csr_op_o(cop[0]), .mret_o(mret[0]), .illegal_instr_o(ill[0]),
        .illegal_cnt_o(cnt0)
    );

    decode_stage #(.XLEN(32), .CSR_EN(1'b0), .CNT_W(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
        .instr_o(instr_o[1]), .pc_o(pc_o[1]), .ex_op_a_sel_o(op_a[1]), .ex_op_b_sel_o(op_b[1]),
        .alu_op_o(alu[1]), .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_size_o(msz[1]),
        .gpr_we_a_o(gwe[1]), .wb_src_sel_o(wb[1]), .branch_o(br[1]), .jal_o(jal[1]), .jalr_o(jalr[1]),
        .csr_we_o(cwe[1]), .csr_op_o(cop[1]), .mret_o(mret[1]), .illegal_instr_o(ill[1]),
        .illegal_cnt_o(cnt1)
    );

    typedef struct packed {
        logic [1:0] a; logic [2:0] b; logic [4:0] alu; logic mreq; logic mwe; logic [2:0] msz;
        logic gwe; logic wb; logic br; logic jal; logic jalr; logic cwe; logic [2:0] cop;
        logic mret; logic ill;
    } exp_t;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    localparam logic [4:0] ARITH [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    localparam logic [4:0] CMP [8]   = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
    localparam logic [6:0] OPCS [11] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                         OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM};
    localparam logic [31:0] SPECIAL [8] = '{INSTR_ECALL, INSTR_EBREAK, INSTR_MRET, 32'h3002_9073,
                                            32'h0000_0000, 32'hFFFF_FFFF, 32'h0031_00B3, 32'h0040_A283};

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t mq[$];
    logic [15:0] mcnt0;
    logic [1:0]  mcnt1;

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.a = OP_A_RS1; e.b = OP_B_RS2; e.alu = ALU_ADD; e.msz = LDST_W; e.wb = WB_EX_RESULT;
        return e;
    endfunction

    // What the architecture says each instruction means.
    function automatic exp_t ref_decode(logic [31:0] w, bit csr_en);
        exp_t e;
        bit ok;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e  = idle_exp();
        ok = (w[1:0] == 2'b11);
        if (op == OPC_LUI) begin
            e.a = OP_A_ZERO; e.b = OP_B_IMM_U; e.gwe = 1;
        end else if (op == OPC_AUIPC) begin
            e.a = OP_A_PC; e.b = OP_B_IMM_U; e.gwe = 1;
        end else if (op == OPC_JAL) begin
            e.a = OP_A_PC; e.b = OP_B_FOUR; e.gwe = 1; e.jal = 1;
        end else if (op == OPC_JALR) begin
            e.a = OP_A_PC; e.b = OP_B_FOUR; e.gwe = 1; e.jalr = 1;
            if (f3 != 0) ok = 0;
        end else if (op == OPC_BRANCH) begin
            e.alu = CMP[f3]; e.br = 1;
            if (f3 == 2 || f3 == 3) ok = 0;
        end else if (op == OPC_LOAD) begin
            e.b = OP_B_IMM_I; e.mreq = 1; e.gwe = 1; e.wb = WB_LSU_DATA; e.msz = f3;
            if (f3 == 3 || f3 > 5) ok = 0;
        end else if (op == OPC_STORE) begin
            e.b = OP_B_IMM_S; e.mreq = 1; e.mwe = 1; e.msz = f3;
            if (f3 > 2) ok = 0;
        end else if (op == OPC_OP_IMM) begin
            e.b = OP_B_IMM_I; e.gwe = 1; e.alu = ARITH[f3];
            if (f3 == 1 && f7 != 0) ok = 0;
            if (f3 == 5) begin
                if (f7 == 7'h20) e.alu = ALU_SRA;
                else if (f7 != 0) ok = 0;
            end
        end else if (op == OPC_OP) begin
            e.gwe = 1;
            if (f7 == 0) e.alu = ARITH[f3];
            else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_SRA;
            else ok = 0;
        end else if (op == OPC_FENCE) begin
            if (f3 != 0) ok = 0;
        end else if (op == OPC_SYSTEM) begin
            if (!csr_en) ok = 0;
            else if (f3 == 0) begin
                if (w == INSTR_MRET) e.mret = 1;
                else if (w != INSTR_ECALL && w != INSTR_EBREAK) ok = 0;
            end else if (f3 == 4) ok = 0;
            else begin
                e.gwe = 1; e.cwe = 1; e.cop = f3;
            end
        end else begin
            ok = 0;
        end
        if (!ok) begin
            e = idle_exp();
            e.ill = 1;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flow model: the stage is a two-deep FIFO whose head is the output bundle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcnt0 = '0;
            mcnt1 = '0;
        end else begin
            bit acc, drn;
            acc = in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && out_ready;
            if (drn) begin
                ent_t h;
                h = mq.pop_front();
                if (ref_decode(h.instr, 1'b1).ill && mcnt0 != 16'hFFFF) mcnt0 = mcnt0 + 1;
                if (ref_decode(h.instr, 1'b0).ill && mcnt1 != 2'd3) mcnt1 = mcnt1 + 1;
            end
            if (flush) mq.delete();
            else if (acc) mq.push_back('{instr, pc});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("out_valid%0d", d), 64'(out_valid[d]), 64'(mq.size() > 0));
                chk($sformatf("in_ready%0d", d), 64'(in_ready[d]), 64'(mq.size() < 2));
                if (mq.size() > 0 && out_valid[d]) begin
                    exp_t act, exp;
                    act = {op_a[d], op_b[d], alu[d], mreq[d], mwe[d], msz[d], gwe[d], wb[d],
                           br[d], jal[d], jalr[d], cwe[d], cop[d], mret[d], ill[d]};
                    exp = ref_decode(mq[0].instr, d == 0);
                    chk($sformatf("bundle%0d instr=%h", d, mq[0].instr), 64'(act), 64'(exp));
                    chk($sformatf("instr_o%0d", d), 64'(instr_o[d]), 64'(mq[0].instr));
                    chk($sformatf("pc_o%0d", d), 64'(pc_o[d]), 64'(mq[0].pc));
                end
            end
            chk("illegal_cnt0", 64'(cnt0), 64'(mcnt0));
            chk("illegal_cnt1", 64'(cnt1), 64'(mcnt1));
        end
    end

    task automatic do_reset();
        rst_n = 0; in_valid = 0; flush = 0; out_ready = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k >= 1 && k <= 7) begin
            w[1:0] = 2'b11;
            w[6:0] = OPCS[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end else if (k > 7) begin
            w = SPECIAL[$urandom_range(0, 7)];
        end
        return w;
    endfunction

    initial begin
        rst_n = 0; in_valid = 0; flush = 0; out_ready = 0; instr = 0; pc = 0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", 64'(out_valid[d]), 64'd0);
            chk("rst_in_ready", 64'(in_ready[d]), 64'd1);
            chk("rst_bundle", 64'({op_a[d], op_b[d], alu[d], msz[d], wb[d], gwe[d], mreq[d], ill[d]}),
                64'({OP_A_RS1, OP_B_RS2, ALU_ADD, LDST_W, WB_EX_RESULT, 3'b000}));
        end
        chk("rst_cnt", 64'({cnt1, cnt0}), 64'd0);
        rst_n = 1;

        // add then lw, no backpressure
        in_valid = 1; instr = 32'h0031_00B3; pc = 32'h100; out_ready = 1;
        @(negedge clk);
        chk("add_valid", 64'(out_valid[0]), 64'd1);
        chk("add_fields", 64'({alu[0], op_a[0], op_b[0], gwe[0], ill[0]}),
            64'({ALU_ADD, OP_A_RS1, OP_B_RS2, 2'b10}));
        instr = 32'h0040_A283; pc = 32'h104;
        @(negedge clk);
        chk("lw_instr", 64'(instr_o[0]), 64'h0040_A283);
        chk("lw_fields", 64'({mreq[0], mwe[0], msz[0], wb[0], op_b[0]}),
            64'({2'b10, LDST_W, WB_LSU_DATA, OP_B_IMM_I}));
        in_valid = 0;
        @(negedge clk);
        chk("lw_drained", 64'(out_valid[0]), 64'd0);

        // backpressure: A, B accepted, C waits
        out_ready = 0; in_valid = 1; instr = 32'h0020_8133; pc = 32'h200;
        @(negedge clk);
        chk("bp_ready1", 64'(in_ready[0]), 64'd1);
        instr = 32'h4020_8133; pc = 32'h204;
        @(negedge clk);
        chk("bp_full", 64'(in_ready[0]), 64'd0);
        chk("bp_headA", 64'(instr_o[0]), 64'h0020_8133);
        instr = 32'h00A0_0093; pc = 32'h208;
        @(negedge clk);
        chk("bp_stable", 64'({in_ready[0], instr_o[0]}), {31'd0, 1'b0, 32'h0020_8133});
        out_ready = 1;
        @(negedge clk);
        chk("bp_headB", 64'({in_ready[0], alu[0], instr_o[0]}), {26'd0, 1'b1, ALU_SUB, 32'h4020_8133});
        @(negedge clk);
        chk("bp_headC", 64'({op_b[0], instr_o[0]}), {29'd0, OP_B_IMM_I, 32'h00A0_0093});
        in_valid = 0;
        @(negedge clk);
        chk("bp_empty", 64'(out_valid[0]), 64'd0);

        // illegal handoffs and counter saturation
        do_reset();
        out_ready = 1; in_valid = 1; instr = 32'h0000_0000;
        @(negedge clk);
        chk("ill0_flags", 64'({ill[0], ill[1], mreq[0], mwe[0], gwe[0], br[0], jal[0], jalr[0], cwe[0], mret[0]}),
            64'b11_0000_0000);
        instr = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("illF_flags", 64'({ill[0], mreq[0], mwe[0], gwe[0], br[0], jal[0], jalr[0], cwe[0], mret[0]}),
            64'b1_0000_0000);
        instr = 32'h0000_0000;
        @(negedge clk);
        chk("ill_cnt2", 64'({cnt1, cnt0}), {46'd0, 2'd2, 16'd2});
        instr = 32'hFFFF_FFFF;
        @(negedge clk);
        instr = 32'h0000_0000;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("ill_cnt5", 64'(cnt0), 64'd5);
        chk("ill_cnt_sat", 64'(cnt1), 64'd3);

        // flush while FULL with a new instruction offered
        do_reset();
        out_ready = 0; in_valid = 1; instr = 32'h0031_00B3; pc = 32'h300;
        @(negedge clk);
        instr = 32'h0040_A283; pc = 32'h304;
        @(negedge clk);
        instr = 32'h00A0_0093; pc = 32'h308; flush = 1;
        @(negedge clk);
        flush = 0; in_valid = 0;
        chk("flush_valid", 64'({out_valid[0], out_valid[1]}), 64'd0);
        chk("flush_ready", 64'({in_ready[0], in_ready[1]}), 64'b11);
        out_ready = 1;
        repeat (3) @(negedge clk);
        chk("flush_gone", 64'(out_valid[0]), 64'd0);

        // CSR write and MRET
        do_reset();
        out_ready = 1; in_valid = 1; instr = 32'h3002_9073; pc = 32'h400;
        @(negedge clk);
        chk("csrrw_en", 64'({cwe[0], cop[0], gwe[0], ill[0]}), {58'd0, 1'b1, CSR_OP_RW, 2'b10});
        chk("csrrw_dis", 64'({ill[1], cwe[1], gwe[1]}), 64'b100);
        instr = INSTR_MRET;
        @(negedge clk);
        chk("mret_en", 64'({mret[0], ill[0], cwe[0], gwe[0]}), 64'b1000);
        chk("mret_dis", 64'({ill[1], mret[1]}), 64'b10);
        in_valid = 0;
        @(negedge clk);

        // randomized traffic with one mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                in_valid = 1; rst_n = 0;
                @(negedge clk);
                chk("midrst_valid", 64'({out_valid[0], out_valid[1]}), 64'd0);
                chk("midrst_ready_cnt", 64'({in_ready[0], in_ready[1], cnt0, cnt1}), {46'd0, 2'b11, 18'd0});
                rst_n = 1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            pc        = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (4) @(negedge clk);
        chk("final_empty", 64'({out_valid[0], out_valid[1]}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
